player_move_ctrl: RTL and testbench

Parametrised player sprite position controller for the Space Invaders VGA pipeline. It replaces the fixed-speed bouncing mover with a keypad-driven mover. Features: fixed-point acceleration and deceleration, saturating borders, an optional autonomous bounce mode, and a hit/freeze/respawn sequence. It sits between the keypad decoder and the player sprite drawer, and updates once per frame on `startOfFrame`.

---
 rtl/player_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// ----------------------------------------------------------------------------
// player_move_ctrl
//   Keypad-driven player sprite position controller. Moves the sprite once
//   per frame on startOfFrame. Position and speed are fixed point with
//   FRAC_BITS fractional bits. The speed ramps by ACCEL per frame up to
//   MAX_SPEED. The position saturates at MIN_X/MAX_X. With AUTO_MODE set the
//   sprite bounces between the borders on its own. A hit freezes the sprite
//   for FREEZE_FRAMES frames, then it respawns at the spawn point.
//
// Ports
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   startOfFrame : one-cycle pulse per frame; triggers the motion update
//   restart      : synchronous game restart (back to spawn, ACTIVE)
//   keyPad       : current key code
//   keyPadValid  : keyPad holds a valid code
//   keyIsPressed : a key is currently held
//   hit          : one-cycle pulse, player struck
//   topLeftX     : sprite X in integer pixels
//   topLeftY     : sprite Y in integer pixels (constant)
//   moving       : speed is non-zero and the sprite is ACTIVE
//   frozen       : sprite is frozen after a hit
// ----------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int INITIAL_X     = 320,
    parameter int INITIAL_Y     = 450,
    parameter int MIN_X         = 0,
    parameter int MAX_X         = 607,
    parameter int FRAC_BITS     = 6,
    parameter int MAX_SPEED     = 128,
    parameter int ACCEL         = 16,
    parameter int AUTO_MODE     = 0,
    parameter int FREEZE_FRAMES = 30,
    parameter int KEY_LEFT      = 4,
    parameter int KEY_RIGHT     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        restart,
    input  logic [3:0]  keyPad,
    input  logic        keyPadValid,
    input  logic        keyIsPressed,
    input  logic        hit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        moving,
    output logic        frozen
);

    localparam int W     = 11 + FRAC_BITS + 2;
    localparam int CNT_W = $clog2(FREEZE_FRAMES + 1);

    typedef logic signed [W-1:0] fixT;

    localparam fixT  SPAWN_POS   = fixT'(INITIAL_X <<< FRAC_BITS);
    localparam fixT  MIN_POS     = fixT'(MIN_X <<< FRAC_BITS);
    localparam fixT  MAX_POS     = fixT'(MAX_X <<< FRAC_BITS);
    localparam fixT  POS_SPD     = fixT'(MAX_SPEED);
    localparam fixT  NEG_SPD     = fixT'(-MAX_SPEED);
    localparam fixT  ACC         = fixT'(ACCEL);
    localparam fixT  NEG_ACC     = fixT'(-ACCEL);
    localparam logic AUTO_ON     = (AUTO_MODE != 0);
    localparam fixT  RESET_SPEED = AUTO_ON ? POS_SPD : fixT'(0);
    localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES);

    typedef enum logic [1:0] {ST_ACTIVE, ST_FROZEN, ST_RESPAWN} stateT;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dirT;

    stateT            state;
    dirT              dir;
    fixT              posX;
    fixT              speed;
    logic [CNT_W-1:0] freezeCnt;

    fixT upSpeed;
    fixT downSpeed;
    fixT accelSpeed;
    fixT nextPos;
    fixT framePos;
    fixT frameSpeed;

    assign topLeftX = posX[FRAC_BITS +: 11];
    assign topLeftY = 11'(INITIAL_Y);

    // Direction follows the keypad every clk; unknown codes keep the last
    // direction so a stray code does not stop the player.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir <= DIR_NONE;
        end else if (!keyIsPressed) begin
            dir <= DIR_NONE;
        end else if (keyPadValid && keyPad == 4'(KEY_LEFT)) begin
            dir <= DIR_LEFT;
        end else if (keyPadValid && keyPad == 4'(KEY_RIGHT)) begin
            dir <= DIR_RIGHT;
        end
    end

    // Result of one frame update in ACTIVE: new speed first, then position
    // with border saturation.
    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        upSpeed    = speed + ACC;
        downSpeed  = speed - ACC;
        accelSpeed = speed;
        if (!AUTO_ON) begin
            case (dir)
                DIR_RIGHT: accelSpeed = (upSpeed > POS_SPD) ? POS_SPD : upSpeed;
                DIR_LEFT:  accelSpeed = (downSpeed < NEG_SPD) ? NEG_SPD : downSpeed;
                default: begin
                    // Coast toward zero without overshooting it.
                    if (speed > ACC)
                        accelSpeed = downSpeed;
                    else if (speed < NEG_ACC)
                        accelSpeed = upSpeed;
                    else
                        accelSpeed = fixT'(0);
                end
            endcase
        end

        nextPos    = posX + accelSpeed;
        framePos   = nextPos;
        frameSpeed = accelSpeed;
        if (nextPos < MIN_POS) begin
            framePos   = MIN_POS;
            frameSpeed = AUTO_ON ? POS_SPD : fixT'(0);
        end else if (nextPos > MAX_POS) begin
            framePos   = MAX_POS;
            frameSpeed = AUTO_ON ? NEG_SPD : fixT'(0);
        end
    end

    // Game state machine. Priority: reset, restart, hit, startOfFrame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ACTIVE;
            posX      <= SPAWN_POS;
            speed     <= RESET_SPEED;
            freezeCnt <= '0;
            moving    <= AUTO_ON;
            frozen    <= 1'b0;
        end else if (restart) begin
            state     <= ST_ACTIVE;
            posX      <= SPAWN_POS;
            speed     <= RESET_SPEED;
            freezeCnt <= '0;
            moving    <= AUTO_ON;
            frozen    <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (hit) begin
                        state     <= ST_FROZEN;
                        speed     <= fixT'(0);
                        freezeCnt <= '0;
                        moving    <= 1'b0;
                        frozen    <= 1'b1;
                    end else if (startOfFrame) begin
                        posX   <= framePos;
                        speed  <= frameSpeed;
                        moving <= (frameSpeed != fixT'(0));
                    end
                end
                ST_FROZEN: begin
                    // Hits are ignored here, so a second hit cannot extend
                    // the freeze.
                    if (freezeCnt == FREEZE_LAST) begin
                        state  <= ST_RESPAWN;
                        frozen <= 1'b0;
                    end else if (startOfFrame) begin
                        freezeCnt <= freezeCnt + 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    state  <= ST_ACTIVE;
                    posX   <= SPAWN_POS;
                    speed  <= RESET_SPEED;
                    moving <= AUTO_ON;
                end
                default: begin
                    state <= ST_ACTIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

    localparam int SPAWN  = 320 * 64;
    localparam int MAXP   = 607 * 64;
    localparam int VMAX   = 128;
    localparam int VACC   = 16;
    localparam int FREEZE = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  keyPad = 4'd0;
    logic        keyPadValid = 1'b0;
    logic        keyIsPressed = 1'b0;
    logic        hit = 1'b0;
    logic        hitAuto = 1'b0;
    logic [10:0] topLeftX, topLeftY, autoX, autoY;
    logic        moving, frozen, autoMoving, autoFrozen;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model, in sub-pixels. mDir: 0 none, 1 left, 2 right.
    int mPos, mSpd, mCnt, mDir;
    bit mFrozen;
    int aPos, aSpd;
    int heldX;

    always #5 clk = ~clk;

    player_move_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .restart(restart),
        .keyPad(keyPad), .keyPadValid(keyPadValid), .keyIsPressed(keyIsPressed),
        .hit(hit), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .moving(moving), .frozen(frozen)
    );

    player_move_ctrl #(.AUTO_MODE(1)) dutAuto (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .restart(restart),
        .keyPad(keyPad), .keyPadValid(keyPadValid), .keyIsPressed(keyIsPressed),
        .hit(hitAuto), .topLeftX(autoX), .topLeftY(autoY),
        .moving(autoMoving), .frozen(autoFrozen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPos = SPAWN; mSpd = 0; mCnt = 0; mFrozen = 0;
        aPos = SPAWN; aSpd = VMAX;
    endtask

    task automatic keyStep();
        int nxt;
        if (mFrozen) begin
            mCnt++;
            if (mCnt == FREEZE) begin
                mFrozen = 0; mPos = SPAWN; mSpd = 0;
            end
        end else begin
            if (mDir == 2)      mSpd = (mSpd + VACC > VMAX) ? VMAX : mSpd + VACC;
            else if (mDir == 1) mSpd = (mSpd - VACC < -VMAX) ? -VMAX : mSpd - VACC;
            else if (mSpd > 0)  mSpd = (mSpd > VACC) ? mSpd - VACC : 0;
            else if (mSpd < 0)  mSpd = (mSpd < -VACC) ? mSpd + VACC : 0;
            nxt = mPos + mSpd;
            if (nxt < 0)         begin mPos = 0;    mSpd = 0; end
            else if (nxt > MAXP) begin mPos = MAXP; mSpd = 0; end
            else                 mPos = nxt;
        end
    endtask

    task automatic autoStep();
        int nxt;
        nxt = aPos + aSpd;
        if (nxt < 0)         begin aPos = 0;    aSpd = VMAX;  end
        else if (nxt > MAXP) begin aPos = MAXP; aSpd = -VMAX; end
        else                 aPos = nxt;
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".x"},     32'(topLeftX), mPos / 64);
        check({tag, ".y"},     32'(topLeftY), 450);
        check({tag, ".mov"},   32'(moving),   (mSpd != 0 && !mFrozen) ? 1 : 0);
        check({tag, ".frz"},   32'(frozen),   mFrozen ? 1 : 0);
        check({tag, ".ax"},    32'(autoX),    aPos / 64);
        check({tag, ".amov"},  32'(autoMoving), 1);
    endtask

    task automatic setKeys(input bit pressed, input bit valid, input logic [3:0] code);
        @(negedge clk);
        keyIsPressed = pressed; keyPadValid = valid; keyPad = code;
        if (!pressed)                  mDir = 0;
        else if (valid && code == 4'd4) mDir = 1;
        else if (valid && code == 4'd6) mDir = 2;
    endtask

    task automatic doFrame(input string tag);
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
        keyStep();
        autoStep();
        checkAll(tag);
    endtask

    task automatic pulseHit();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
        if (!mFrozen) begin
            mFrozen = 1; mSpd = 0; mCnt = 0;
        end
        checkAll("hit");
    endtask

    task automatic pulseRestart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        modelReset();
        checkAll("restart");
    endtask

    initial begin
        bit   pr, va;
        logic [3:0] cd;
        int   r;

        // Reset state and one idle frame.
        mDir = 0;
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkAll("reset");
        doFrame("idle");
        check("idle.x320", 32'(topLeftX), 320);

        // Accelerate right for 10 frames, then coast to a stop.
        setKeys(1, 1, 4'd6);
        repeat (10) doFrame("accel");
        check("accel.x333", 32'(topLeftX), 333);
        setKeys(0, 0, 4'd6);
        repeat (8) doFrame("coast");
        check("coast.mov0", 32'(moving), 0);
        check("coast.x340", 32'(topLeftX), 340);

        // Saturate at both borders.
        setKeys(1, 1, 4'd6);
        repeat (150) doFrame("right");
        check("right.x607", 32'(topLeftX), 607);
        check("right.mov0", 32'(moving), 0);
        setKeys(1, 1, 4'd4);
        repeat (330) doFrame("left");
        check("left.x0", 32'(topLeftX), 0);
        check("left.mov0", 32'(moving), 0);

        // Run right to about X=400 and get hit while moving.
        setKeys(1, 1, 4'd6);
        for (int i = 0; i < 300 && mPos / 64 < 400; i++) doFrame("toHit");
        check("toHit.mov", 32'(moving), 1);
        heldX = mPos / 64;
        pulseHit();
        check("hit.held", 32'(topLeftX), heldX);
        repeat (10) doFrame("frz");
        pulseHit();
        repeat (19) doFrame("frz2");
        // 30th frame of the freeze, checked clk by clk.
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        check("frz30.frz", 32'(frozen), 1);
        @(negedge clk);
        check("respawn.frz", 32'(frozen), 0);
        check("respawn.x", 32'(topLeftX), heldX);
        @(negedge clk);
        check("spawn.x", 32'(topLeftX), 320);
        check("spawn.mov", 32'(moving), 0);
        keyStep();
        autoStep();
        @(negedge clk);
        checkAll("spawn");

        // Hit coincident with a frame: no movement that frame.
        repeat (4) doFrame("pre");
        heldX = mPos / 64;
        @(negedge clk) begin hit = 1'b1; startOfFrame = 1'b1; end
        @(negedge clk) begin hit = 1'b0; startOfFrame = 1'b0; end
        mFrozen = 1; mSpd = 0; mCnt = 0;
        autoStep();
        repeat (3) @(negedge clk);
        checkAll("hitSof");
        check("hitSof.x", 32'(topLeftX), heldX);

        // restart + hit + frame in the same clk.
        @(negedge clk) begin restart = 1'b1; hit = 1'b1; startOfFrame = 1'b1; end
        @(negedge clk) begin restart = 1'b0; hit = 1'b0; startOfFrame = 1'b0; end
        modelReset();
        check("rst3.frz", 32'(frozen), 0);
        check("rst3.x", 32'(topLeftX), 320);
        repeat (2) @(negedge clk);
        checkAll("rst3");

        // Randomized key/hit/restart traffic.
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       pulseHit();
            else if (r < 11) pulseRestart();
            pr = ($urandom_range(0, 3) != 0);
            va = ($urandom_range(0, 5) != 0);
            r  = int'($urandom_range(0, 2));
            cd = (r == 0) ? 4'd4 : (r == 1) ? 4'd6 : 4'($urandom_range(0, 15));
            setKeys(pr, va, cd);
            repeat ($urandom_range(1, 12)) doFrame("rand");
        end

        // Reset in the middle of a freeze.
        setKeys(0, 0, 4'd0);
        if (mFrozen) repeat (FREEZE) doFrame("drain");
        pulseHit();
        repeat (5) doFrame("preRst");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("asyncRst.frz", 32'(frozen), 0);
        check("asyncRst.x", 32'(topLeftX), 320);
        check("asyncRst.ax", 32'(autoX), 320);
        @(negedge clk) reset = 1'b0;
        mDir = 0;
        modelReset();
        @(negedge clk);
        checkAll("postRst");
        doFrame("postRst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
